// File: rtl/truth_table_extractor_pkg.sv
// truth_table_pkg: shared state encoding and sizing helpers for the truth-table extractor.
package truth_table_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int SETTLE_DEFAULT = 4;
  function automatic int TT_WIDTH(input int n);
    return 2 ** n;
  endfunction
endpackage

// File: rtl/truth_table_extractor_settle_timer.sv
// settle_timer: loadable down-counter; o_tc pulses on the last cycle of each hold interval and reloads.
module settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_tc  = i_en && r_cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load || o_tc) r_cnt <= i_load_val;
    else if (i_en) r_cnt <= r_cnt - 1'b1;
  end
endmodule

// File: rtl/truth_table_extractor.sv
// truth_table_extractor: sweeps all GUT input combinations and assembles the hex truth-table code.
// Optional TRUTH_TABLE_STABILITY_CHECK_EN adds one extra hold cycle per combination to detect late-settling outputs.
module truth_table_extractor import truth_table_pkg::*; #(
  parameter int N_IN = 3,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter logic [TT_WIDTH(N_IN)-1:0] EXPECTED = 8'hE9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [N_IN-1:0]           drive,
  input  logic                      sample,
  output logic                      busy,
  output logic                      done,
  output logic [TT_WIDTH(N_IN)-1:0] table_out,
  output logic                      valid,
  output logic                      match,
  output logic                      unstable
);
  localparam int W = TT_WIDTH(N_IN);
`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
  localparam int HOLD = SETTLE_CYCLES + 1;
`else
  localparam int HOLD = SETTLE_CYCLES;
`endif
  localparam int CW = $clog2(HOLD + 1);
  // the timer counts down, so the capture point sits HOLD-SETTLE_CYCLES cycles before terminal count
  localparam logic [CW-1:0] CAP_AT = CW'(HOLD - SETTLE_CYCLES);
  localparam logic [N_IN:0] K_LAST = (N_IN + 1)'(W - 1);
  state_t           r_state;
  logic [N_IN:0]    r_k;
  logic [N_IN-1:0]  r_drive;
  logic [W-1:0]     r_table;
  logic             r_busy, r_done, r_valid, r_match, r_unstable;
  logic [CW-1:0]    w_cnt;
  logic             w_tc, w_cap;
  logic [N_IN-1:0]  w_pos;
  settle_timer #(.W(CW)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_load(r_state != DRIVE),
    .i_en(r_state == DRIVE),
    .i_load_val(CW'(HOLD - 1)),
    .o_cnt(w_cnt),
    .o_tc(w_tc)
  );
  assign w_cap = r_state == DRIVE && w_cnt == CAP_AT;
  assign w_pos = ~r_k[N_IN-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_drive    <= '0;
      r_table    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_match    <= 1'b0;
      r_unstable <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_table    <= '0;
          r_valid    <= 1'b0;
          r_match    <= 1'b0;
          r_unstable <= 1'b0;
          r_k        <= '0;
          r_drive    <= '0;
          r_busy     <= 1'b1;
          r_state    <= DRIVE;
        end
        DRIVE: begin
          if (w_cap) r_table[w_pos] <= sample;
`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
          if (w_tc && sample != r_table[w_pos]) r_unstable <= 1'b1;
`endif
          if (w_tc) begin
            r_k     <= r_k + 1'b1;
            r_drive <= r_k == K_LAST ? '0 : r_drive + 1'b1;
            r_done  <= r_k == K_LAST;
            r_state <= r_k == K_LAST ? DONE : DRIVE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_match <= r_table == EXPECTED && !r_unstable;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign drive     = r_drive;
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign valid     = r_valid;
  assign match     = r_match;
  assign unstable  = r_unstable;
endmodule

// File: tb/tb_truth_table_extractor.sv
// tb_truth_table_extractor: scoreboard bench for truth_table_extractor (honours TRUTH_TABLE_STABILITY_CHECK_EN).
module tb_truth_table_extractor;
  localparam int S = 4;
`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  localparam int HOLD = S + EXT;
  localparam int LAT = 8 * HOLD + 1;
  localparam int LAT2 = 4 * (1 + EXT) + 1;
  typedef struct { logic [7:0] tbl; logic m; logic u; int lat; } exp_t;
  logic clk = 0, rst = 1, start = 0, start2 = 0;
  logic [2:0] drive;
  logic sample, busy, done, valid, match, unstable;
  logic [7:0] table_out;
  logic [1:0] drive2;
  logic busy2, done2, valid2, match2, unstable2;
  logic [3:0] table2;
  int mode = 0, total = 0, bad = 0;
  logic [7:0] f_e9 = 8'hE9;
  logic [2:0] pd = 0;
  int hc = 0, idx;
  exp_t sb[$];
  logic [2:0] trace [0:127];
  int g_lat;
  logic [7:0] g_tbl;
  logic g_valid, g_match, g_unst, g_done, g_busy;
  always #5 clk = ~clk;
  truth_table_extractor u_dut (
    .clk(clk), .rst(rst), .start(start), .drive(drive), .sample(sample), .busy(busy),
    .done(done), .table_out(table_out), .valid(valid), .match(match), .unstable(unstable)
  );
  truth_table_extractor #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECTED(4'b0110)) u_small (
    .clk(clk), .rst(rst), .start(start2), .drive(drive2), .sample(^drive2), .busy(busy2),
    .done(done2), .table_out(table2), .valid(valid2), .match(match2), .unstable(unstable2)
  );
  always @(posedge clk) begin
    pd <= drive;
    hc <= (drive != pd) ? 1 : hc + 1;
  end
  assign idx = (drive != pd) ? 0 : hc;
  always_comb begin
    sample = f_e9[~drive];
    if (mode == 1) sample = 1'b1;
    else if (mode == 2) sample = drive[2];
    else if (mode == 3 && drive == 3'd5 && idx < S) sample = ~f_e9[~drive];
  end
  task automatic run_sweep(input bit hold);
    g_lat = 0;
    @(negedge clk); start = 1;
    @(negedge clk); if (!hold) start = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      trace[c] = drive;
      if (done) begin g_lat = c; break; end
    end
    @(negedge clk);
    g_tbl = table_out; g_valid = valid; g_match = match; g_unst = unstable; g_done = done; g_busy = busy;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if ({drive, busy, done, table_out, valid, match, unstable} !== 16'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {drive, busy, done, table_out, valid, match, unstable});
    end
    rst = 0;
    @(negedge clk);
    total++; if ({busy, valid, table_out} !== 10'd0) begin
      bad++; $display("FAIL idle_after_reset got=%h want=0", {busy, valid, table_out});
    end
  endtask
  task automatic test_sweep(input int m, input logic [7:0] t, input logic mt, input logic u, input string nm);
    exp_t e;
    mode = m;
    sb.push_back('{t, mt, u, LAT});
    run_sweep(0);
    e = sb.pop_front();
    total++; if (g_lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, g_lat, e.lat); end
    total++; if (g_tbl !== e.tbl) begin bad++; $display("FAIL %s_table got=%h want=%h", nm, g_tbl, e.tbl); end
    total++; if (g_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", nm, g_valid); end
    total++; if (g_match !== e.m) begin bad++; $display("FAIL %s_match got=%b want=%b", nm, g_match, e.m); end
    total++; if (g_unst !== e.u) begin bad++; $display("FAIL %s_unstable got=%b want=%b", nm, g_unst, e.u); end
    total++; if (g_done !== 1'b0 || g_busy !== 1'b0) begin
      bad++; $display("FAIL %s_done_pulse got done=%b busy=%b want 0 0", nm, g_done, g_busy);
    end
  endtask
  task automatic test_drive_steps();
    test_sweep(0, 8'hE9, 1'b1, 1'b0, "basic");
    for (int c = 1; c <= 8 * HOLD; c++) begin
      total++; if (trace[c] !== 3'((c - 1) / HOLD)) begin
        bad++; $display("FAIL drive_step c=%0d got=%0d want=%0d", c, trace[c], (c - 1) / HOLD);
      end
    end
    total++; if (trace[LAT] !== 3'd0) begin bad++; $display("FAIL drive_in_done got=%0d want=0", trace[LAT]); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    mode = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++; if ({drive, busy, done, valid, table_out} !== 14'd0) begin
      bad++; $display("FAIL reset_mid got=%h want=0", {drive, busy, done, valid, table_out});
    end
    rst = 0;
    repeat (40) begin @(negedge clk); if (done || busy) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d want=0", n); end
    test_sweep(0, 8'hE9, 1'b1, 1'b0, "after_reset");
  endtask
  task automatic test_start_held();
    exp_t e;
    int n = 0;
    mode = 0;
    sb.push_back('{8'hE9, 1'b1, 1'b0, LAT});
    run_sweep(1);
    start = 0;
    e = sb.pop_front();
    total++; if (g_lat !== e.lat) begin bad++; $display("FAIL held_latency got=%0d want=%0d", g_lat, e.lat); end
    total++; if (g_tbl !== e.tbl || g_match !== e.m) begin
      bad++; $display("FAIL held_result got=%h/%b want=%h/%b", g_tbl, g_match, e.tbl, e.m);
    end
    total++; if (g_busy !== 1'b0) begin bad++; $display("FAIL held_idle_busy got=%b want=0", g_busy); end
    repeat (40) begin @(negedge clk); if (done || busy) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL held_one_sweep got=%0d want=0", n); end
  endtask
`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
  task automatic test_stability();
    test_sweep(3, 8'hED, 1'b0, 1'b1, "unstable");
    test_sweep(0, 8'hE9, 1'b1, 1'b0, "stable");
  endtask
`endif
  task automatic test_small();
    exp_t e;
    int lat = 0;
    sb.push_back('{8'h06, 1'b1, 1'b0, LAT2});
    @(negedge clk); start2 = 1;
    @(negedge clk); start2 = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c > 1) @(negedge clk);
      if (done2) begin lat = c; break; end
    end
    @(negedge clk);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL small_latency got=%0d want=%0d", lat, e.lat); end
    total++; if ({4'd0, table2} !== e.tbl) begin bad++; $display("FAIL small_table got=%b want=%b", table2, e.tbl[3:0]); end
    total++; if (valid2 !== 1'b1 || match2 !== e.m || unstable2 !== e.u) begin
      bad++; $display("FAIL small_flags got=%b%b%b want=1%b%b", valid2, match2, unstable2, e.m, e.u);
    end
  endtask
  initial begin
    test_reset();
    test_drive_steps();
    test_sweep(1, 8'hFF, 1'b0, 1'b0, "const1");
    test_sweep(2, 8'h0F, 1'b0, 1'b0, "in1");
    test_reset_mid();
    test_start_held();
`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
    test_stability();
`endif
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
